lru_replacement_ctrl: RTL
=========================

Name: lru_replacement_ctrl

Overview:
- Sequences counter-based LRU replacement for one N-way set-associative cache: stores per-set age counters and valid bits, serves one access or invalidate per transaction, returns the victim way on misses.
- Sits beside tag compare: tag logic supplies the set index, hit/miss and hit way; this block answers with the way to fill or evict.
- Supported geometries: 4-way and 8-way.

Parameters:
- WAYS, 4, associativity; legal values 4 or 8.
- SETS, 16, number of sets; power of two, at least 2.
- AGE_W, $clog2(WAYS), width of one age counter.
- IDX_W, $clog2(SETS), width of the set index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00=HIT, 01=MISS, 10=INVAL, 11=reserved.
- req_set  in  IDX_W  set index.
- req_way  in  AGE_W  hit way for HIT, target way for INVAL; ignored for MISS.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_way  out  AGE_W  way touched; victim way for MISS.
- resp_evict  out  1  MISS replaced a valid line.
- resp_err  out  1  illegal request; state unchanged.

Behaviour:
- Reset, asynchronous: state=IDLE, req_ready=1, resp_valid=0, resp_way=0, resp_evict=0, resp_err=0. Every set gets age[w]=w and valid[w]=0.
- Age invariant: in every set, the ages form a permutation of 0..WAYS-1. WAYS-1 is most recent; 0 is least recent.
- FSM states: IDLE, LOOKUP, UPDATE, RESP.
- IDLE: req_ready=1. On req_valid, register op/set/way and go to LOOKUP. req_ready is 0 in every other state, so there is no overlap.
- LOOKUP: read the set row.
  - Victim is the lowest-index invalid way.
  - If all ways are valid, victim is the way with age 0.
  - Go to UPDATE.
- UPDATE: write the row, then go to RESP. Let t be the target way (hit way, victim or inval way) and a = age[t].
  - HIT: ways with age > a decrement; age[t]=WAYS-1. resp_way=t.
  - MISS: same aging applied to the victim; valid[victim]=1. resp_way=victim. resp_evict=1 only if the victim was valid before the fill.
  - INVAL: ways with age < a increment; age[t]=0; valid[t]=0. resp_way=t.
- resp_err=1 with no row write on:
  - HIT to an invalid way;
  - op=11;
  - req_way >= WAYS (only reachable when WAYS is not a power of two).
- RESP: resp_valid=1 and outputs held stable until resp_ready. On the handshake go to IDLE; next accept is possible the following cycle.
- Latency: accept edge to resp_valid high is 3 cycles; throughput is one transaction per 4 cycles with resp_ready tied high.
- Same-set back-to-back requests always see the previous update, because there is no overlap.
- INVAL of an already invalid way: still reorders ages as above; resp_err=0.
- Reset mid-transaction: the transaction is dropped, all storage reinitialised, the block returns to IDLE.
- Storage is flops with asynchronous reset, SETS*WAYS*(AGE_W+1) bits.

Decomposition:
- Package lru_pkg holds:
  - the op enum HIT/MISS/INVAL/RSVD;
  - the state enum IDLE/LOOKUP/UPDATE/RESP;
  - the age_w(ways) function.
- Sub-module lru_age_update: purely combinational.
  - Inputs: row ages, target way, mode (promote or demote).
  - Output: new row ages.
  - Instantiated once and shared by all ops.

Test Plan:
- Reset, then MISS set 3 four times (WAYS=4) -> resp_way 0,1,2,3; resp_evict=0 each time; final ages {w0..w3} = {0,1,2,3}.
- After the fills, HIT set 3 way 0 -> ages {3,0,1,2}. A following MISS set 3 -> resp_way=1, resp_evict=1, ages {2,3,0,1}.
- INVAL set 3 way 0 with ages {2,3,0,1} -> ages {0,3,1,2}, valid[0]=0. Next MISS -> resp_way=0, resp_evict=0.
- HIT set 5 way 2 right after reset -> resp_err=1, set 5 unchanged. Also op=11 on any set -> resp_err=1, no state change.
- Hold resp_ready=0 for 5 cycles -> resp_valid stays 1, outputs stable, req_ready=0. The next req_valid is accepted the cycle after resp_ready rises.
- Assert rst_n=0 during UPDATE of a HIT -> outputs return to reset values immediately and set ages return to {0,1,2,3}. Repeat the first scenario with WAYS=8 -> victims 0..7 in order.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared types and helpers for the counter-based LRU replacement controller.
package lru_pkg;

    typedef enum logic [1:0] {
        OP_HIT   = 2'b00,
        OP_MISS  = 2'b01,
        OP_INVAL = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Promote moves the target to most-recent, demote moves it to least-recent.
    typedef enum logic {
        AGE_PROMOTE = 1'b0,
        AGE_DEMOTE  = 1'b1
    } age_mode_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic int age_w(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/lru_age_update.sv
// Recomputes one row of age counters so the target way becomes most or least
// recent while the row stays a permutation of 0..WAYS-1.
module lru_age_update
    import lru_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int AGE_W = age_w(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages,
    input  logic [AGE_W-1:0]           target,
    input  age_mode_e                  mode,
    output logic [WAYS-1:0][AGE_W-1:0] new_ages
);

    logic [AGE_W-1:0] target_age;

    // NOTE: every output of a combinational block gets a default on entry so
    // no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        target_age = ages[target];
        for (int w = 0; w < WAYS; w++) begin
            new_ages[w] = ages[w];
            if (w == int'(target)) begin
                new_ages[w] = (mode == AGE_PROMOTE) ? AGE_W'(WAYS - 1) : '0;
            end else if (mode == AGE_PROMOTE && ages[w] > target_age) begin
                new_ages[w] = ages[w] - AGE_W'(1);
            end else if (mode == AGE_DEMOTE && ages[w] < target_age) begin
                new_ages[w] = ages[w] + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/lru_replacement_ctrl.sv
// Per-set LRU age and valid storage with a four-state request sequencer that
// returns the way to touch, fill or evict for each tag-compare result.
module lru_replacement_ctrl
    import lru_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 16,
    parameter int AGE_W = $clog2(WAYS),
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_set,
    input  logic [AGE_W-1:0] req_way,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [AGE_W-1:0] resp_way,
    output logic             resp_evict,
    output logic             resp_err
);

    typedef logic [WAYS-1:0][AGE_W-1:0] row_t;

    row_t             age_q   [SETS];
    logic [WAYS-1:0]  valid_q [SETS];

    logic [1:0]       state_q;
    op_e              op_q;
    logic [IDX_W-1:0] set_q;
    logic [AGE_W-1:0] way_q;
    logic [AGE_W-1:0] target_q;
    logic             err_q;
    logic             evict_q;

    row_t             row_ages;
    row_t             new_ages;
    logic [WAYS-1:0]  row_valid;
    logic [AGE_W-1:0] victim;
    logic             found_invalid;
    logic             lookup_err;
    age_mode_e        mode;

    assign row_ages   = age_q[set_q];
    assign row_valid  = valid_q[set_q];
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign mode       = (op_q == OP_INVAL) ? AGE_DEMOTE : AGE_PROMOTE;

    // Fill an empty way first; only when the set is full evict the oldest line.
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !row_valid[w]) begin
                victim        = AGE_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (row_ages[w] == '0) victim = AGE_W'(w);
            end
        end
    end

    always_comb begin
        lookup_err = 1'b0;
        case (op_q)
            OP_HIT:   lookup_err = (int'(way_q) >= WAYS) || !row_valid[way_q];
            OP_INVAL: lookup_err = (int'(way_q) >= WAYS);
            OP_RSVD:  lookup_err = 1'b1;
            default:  lookup_err = 1'b0;
        endcase
    end

    lru_age_update #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_age_update (
        .ages     (row_ages),
        .target   (target_q),
        .mode     (mode),
        .new_ages (new_ages)
    );

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_HIT;
            set_q      <= '0;
            way_q      <= '0;
            target_q   <= '0;
            err_q      <= 1'b0;
            evict_q    <= 1'b0;
            resp_way   <= '0;
            resp_evict <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_e'(req_op);
                        set_q   <= req_set;
                        way_q   <= req_way;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    target_q <= (op_q == OP_MISS) ? victim : way_q;
                    err_q    <= lookup_err;
                    evict_q  <= (op_q == OP_MISS) && row_valid[victim];
                    state_q  <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    resp_way   <= target_q;
                    resp_evict <= evict_q && !err_q;
                    resp_err   <= err_q;
                    state_q    <= ST_RESP;
                end
                default: begin
                    if (resp_ready) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the age/valid storage is plain flops, so it is reset explicitly;
    // the age invariant must hold from the first access after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
                valid_q[s] <= '0;
            end
        end else if (state_q == ST_UPDATE && !err_q) begin
            age_q[set_q] <= new_ages;
            if (op_q == OP_MISS) begin
                valid_q[set_q][target_q] <= 1'b1;
            end else if (op_q == OP_INVAL) begin
                valid_q[set_q][target_q] <= 1'b0;
            end
        end
    end

endmodule
